iir_notch_sequencer: RTL and testbench
======================================

# iir_notch_sequencer

Time-multiplexed controller for the IIR notch biquad section. It accepts one input sample per handshake and steps a single shared signed multiplier through the five products b0·x[n], b1·x[n-1], b2·x[n-2], a1·y[n-1] and a2·y[n-2]. It accumulates the products into a 2·WIDTH+5-bit sum and returns a WIDTH-bit output sample. It also owns the coefficient registers and the filter delay line, and sits between the upstream sample stream and the downstream DFE stage.

## Interface
- WIDTH, 16: sample and coefficient width, two's complement
- FRAC, 14: fractional bits of the coefficients; the output is acc >>> FRAC
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  WIDTH  x[n], signed
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  WIDTH  y[n], signed
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 are ignored
- cfg_data  in  WIDTH  coefficient value, signed, with FRAC fractional bits
- state_clr  in  1  synchronous clear of the delay line
- busy  out  1  high in MAC or OUT

## Operation
- The FSM has three states: IDLE, MAC, OUT.
  - IDLE: in_ready=1. On in_valid, latch x, clear acc, load step k=0 and go to MAC.
  - MAC: runs five cycles, k=0..4. Each cycle performs acc <= acc ± coef[k]·operand[k].
    - Signs: + for b0, b1, b2; − for a1, a2.
    - Operands: x, x1, x2, y1, y2.
    - After k=4, go to OUT.
  - OUT: out_valid=1. out_data comes from a register and stays stable. On out_ready, update the delay line, then go to IDLE.
- Arithmetic widths:
  - Product: 2·WIDTH bits, sign-extended into acc.
  - acc: 2·WIDTH+5 bits. It cannot overflow for any inputs.
  - out_data = low WIDTH bits of (acc >>> FRAC). The shift is arithmetic (floor); there is no rounding.
- Delay-line update, on the OUT handshake only: x2<=x1, x1<=x, y2<=y1, y1<=out_data. y1 takes the post-wrap or post-saturation value that is actually emitted.
- Coefficients:
  - cfg writes go to shadow registers at any time. A later write to the same address overwrites the earlier one.
  - Shadow values are copied to the active bank on the IDLE accept edge. A sample already in MAC or OUT always uses one consistent coefficient set.
- state_clr:
  - Clears x1, x2, y1 and y2 on any cycle.
  - If asserted during MAC, the current sample completes with the values already read, but the delay-line update at its OUT handshake is suppressed (the line stays zero).
  - state_clr does not affect coefficients.

## Timing
- Reset values:
  - State IDLE; in_ready=1; out_valid=0; out_data=0; busy=0.
  - acc, delay line, active and shadow coefficients all 0.
- Latency:
  - Sample accepted at edge T. MAC occupies cycles T+1..T+5.
  - out_valid=1 from cycle T+6.
- Throughput: one sample per 7 cycles when out_ready is held high.
- in_ready=0 in MAC and OUT. in_valid held during that time is not consumed.
- Backpressure: out_valid stays high and out_data stays stable until out_ready. The next sample cannot be accepted until the cycle after the OUT handshake.
- cfg_we in the same cycle as an IDLE accept: the new value is written to shadow and also bypasses into the active bank for that sample.
- Reset asserted mid-MAC or mid-OUT: all state is lost immediately and no output is emitted.

## Configuration
- IIR_NOTCH_SAT_EN defined: out_data = (acc >>> FRAC) saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Not defined: out_data = (acc >>> FRAC) truncated, i.e. two's-complement wrap.
- The delay line stores whichever value is emitted.

## Structure
- Shared package notch_pkg holds:
  - the state enum (IDLE/MAC/OUT);
  - the coefficient index constants COEF_B0..COEF_A2 and NUM_TAPS=5;
  - the accumulator width expression 2·WIDTH+5.
- One sub-module, notch_mac_unit: registered accumulator with a combinational signed multiply and an add/subtract select. The sequencer drives its operand muxes and its clear and enable controls.

## Test plan
All scenarios use WIDTH=16, FRAC=14.
- Passthrough: b0=16384, others 0. Accept x=1000 at T → out_valid at T+6 with out_data=1000. busy is high for T+1..T+6.
- Recursion: b0=16384, a1=−8192. Impulse 1000, then 0, 0 → outputs 1000, 500, 250.
- Backpressure: out_ready held low for 10 cycles → out_data stable, in_ready=0, the next in_valid is not consumed. Accept resumes the cycle after the handshake.
- Deferred config: write b0=8192 during MAC of sample x=1000 (b0 was 16384) → output 1000. The next x=1000 → 500.
- Overflow: b0=32767, x=30000.
  - With IIR_NOTCH_SAT_EN → 32767.
  - Without → −5538.
- Async reset mid-MAC: rst pulsed at T+3 → out_valid=0, in_ready=1, and a subsequent passthrough sample shows a zero delay line.

Source files
------------

// File: rtl/notch_pkg.sv
// Shared definitions for the notch biquad sequencer: FSM states, tap indices
// and the accumulator width (2*WIDTH+5 bits, enough headroom for five full-scale products).
package notch_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam int COEF_B0  = 0;
  localparam int COEF_B1  = 1;
  localparam int COEF_B2  = 2;
  localparam int COEF_A1  = 3;
  localparam int COEF_A2  = 4;
  localparam int NUM_TAPS = 5;

  function automatic int acc_width(input int width);
    return 2 * width + 5;
  endfunction

endpackage

// File: rtl/notch_mac_unit.sv
// Registered signed accumulator fed by one combinational multiplier; sum is the
// pre-register value so the caller can capture the final result on the last step.
module notch_mac_unit
  import notch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = acc_width(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    sub,
  input  logic signed [WIDTH-1:0] coef,
  input  logic signed [WIDTH-1:0] operand,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;

  assign prod     = coef * operand;
  assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign sum      = sub ? (acc - prod_ext) : (acc + prod_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/iir_notch_sequencer.sv
// Time-multiplexed notch biquad: accept -> 5 MAC cycles -> registered output held until out_ready.
// Define IIR_NOTCH_SAT_EN to saturate the output instead of two's-complement wrapping.
module iir_notch_sequencer
  import notch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic signed [WIDTH-1:0] cfg_data,
  input  logic                    state_clr,
  output logic                    busy
);

  localparam int ACC_W = acc_width(WIDTH);
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  state_t state, state_nxt;
  logic [2:0] k;
  logic       accept, fire, clr_pend;

  logic signed [WIDTH-1:0] shadow [NUM_TAPS];
  logic signed [WIDTH-1:0] active [NUM_TAPS];
  logic signed [WIDTH-1:0] opnd   [NUM_TAPS];
  logic signed [WIDTH-1:0] x1, x2, y1, y2, out_reg, y_new;
  logic signed [ACC_W-1:0] acc, mac_sum, shifted;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MAC;
      end
      MAC:  if (k == 3'(COEF_A2)) state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = (state == IDLE) && in_valid;
  assign fire     = (state == OUT) && out_ready;
  assign out_data = out_reg;

  notch_mac_unit #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state == MAC),
    .sub     (k >= 3'(COEF_A1)),
    .coef    (active[k]),
    .operand (opnd[k]),
    .acc     (acc),
    .sum     (mac_sum)
  );

  assign shifted = mac_sum >>> FRAC;

`ifdef IIR_NOTCH_SAT_EN
  always_comb begin
    if (shifted > Y_MAX)      y_new = Y_MAX[WIDTH-1:0];
    else if (shifted < Y_MIN) y_new = Y_MIN[WIDTH-1:0];
    else                      y_new = shifted[WIDTH-1:0];
  end
`else
  assign y_new = shifted[WIDTH-1:0];
`endif

  // Operands and coefficients are snapshotted at accept, so a sample in flight
  // never sees cfg writes or state_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      clr_pend <= 1'b0;
      out_reg  <= '0;
      x1       <= '0;
      x2       <= '0;
      y1       <= '0;
      y2       <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        opnd[i]   <= '0;
      end
    end else begin
      state <= state_nxt;
      if (cfg_we && (cfg_addr < 3'(NUM_TAPS))) shadow[cfg_addr] <= cfg_data;

      if (accept) begin
        k        <= '0;
        clr_pend <= 1'b0;
        for (int i = 0; i < NUM_TAPS; i++)
          active[i] <= (cfg_we && cfg_addr == 3'(i)) ? cfg_data : shadow[i];
        opnd[COEF_B0] <= in_data;
        opnd[COEF_B1] <= state_clr ? '0 : x1;
        opnd[COEF_B2] <= state_clr ? '0 : x2;
        opnd[COEF_A1] <= state_clr ? '0 : y1;
        opnd[COEF_A2] <= state_clr ? '0 : y2;
      end else if (state != IDLE && state_clr) begin
        clr_pend <= 1'b1;
      end

      if (state == MAC) begin
        k <= k + 3'd1;
        if (k == 3'(COEF_A2)) out_reg <= y_new;
      end

      if (state_clr) begin
        x1 <= '0;
        x2 <= '0;
        y1 <= '0;
        y2 <= '0;
      end else if (fire && !clr_pend) begin
        x2 <= x1;
        x1 <= opnd[COEF_B0];
        y2 <= y1;
        y1 <= out_reg;
      end
    end
  end

endmodule

// File: tb/tb_iir_notch_sequencer.sv
// Directed bench for iir_notch_sequencer with an expected-output queue.
module tb_iir_notch_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               cfg_we;
  logic [2:0]         cfg_addr;
  logic signed [15:0] cfg_data;
  logic               state_clr;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  logic signed [15:0] sb [$];

`ifdef IIR_NOTCH_SAT_EN
  localparam int EXP_OVF = 32767;
`else
  localparam int EXP_OVF = -5538;
`endif

  iir_notch_sequencer #(.WIDTH(16), .FRAC(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .state_clr (state_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cfg(input logic [2:0] addr, input logic signed [15:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_clr();
    state_clr = 1'b1;
    @(negedge clk);
    state_clr = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic signed [15:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check(tag, out_data, e);
    end
  endtask

  // mid: 0 none, 1 write b0=8192 during MAC, 2 state_clr during MAC
  task automatic send(input string tag, input logic signed [15:0] x,
                      input logic signed [15:0] exp_y, input int mid);
    int n;
    sb.push_back(exp_y);
    in_valid = 1'b1; in_data = x;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; state_clr = 1'b0;
    n = 1;
    check({tag, "_busy_mac"}, busy, 1);
    check({tag, "_in_ready_mac"}, in_ready, 0);
    while (!out_valid && n < 20) begin
      if (n == 2 && mid == 1) begin cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'sd8192; end
      if (n == 2 && mid == 2) state_clr = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; state_clr = 1'b0;
      n++;
    end
    check({tag, "_latency"}, n, 6);
    check({tag, "_busy_out"}, busy, 1);
    pop_check(tag);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_in_ready_after"}, in_ready, 1);
    end
  endtask

  initial begin
    int n;
    logic ok;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; state_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);

    // Passthrough
    cfg(3'd0, 16'sd16384);
    send("pass", 16'sd1000, 16'sd1000, 0);

    // Recursion: y = x - a1*y1 with a1 = -0.5
    pulse_clr();
    cfg(3'd3, -16'sd8192);
    send("rec0", 16'sd1000, 16'sd1000, 0);
    send("rec1", 16'sd0, 16'sd500, 0);
    send("rec2", 16'sd0, 16'sd250, 0);

    // state_clr mid-MAC suppresses the delay-line update
    pulse_clr();
    send("clr0", 16'sd1000, 16'sd1000, 2);
    send("clr1", 16'sd0, 16'sd0, 0);

    // Backpressure
    cfg(3'd3, 16'sd0);
    pulse_clr();
    out_ready = 1'b0;
    send("bp0", 16'sd1000, 16'sd1000, 0);
    in_valid = 1'b1; in_data = 16'sd777;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_data !== 16'sd1000 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    check("bp_hold_stable", ok, 1);
    out_ready = 1'b1; in_data = 16'sd2000;
    sb.push_back(16'sd2000);
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted", busy, 1);
    n = 1;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("bp1_latency", n, 6);
    pop_check("bp1");
    @(negedge clk);

    // Deferred config, then cfg write bypassing on the accept edge
    send("defer0", 16'sd1000, 16'sd1000, 1);
    send("defer1", 16'sd1000, 16'sd500, 0);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'sd16384;
    send("bypass", 16'sd1000, 16'sd1000, 0);

    // Overflow
    pulse_clr();
    cfg(3'd0, 16'sd32767);
    send("ovf", 16'sd30000, 16'(EXP_OVF), 0);

    // Async reset mid-MAC (delay line holds x1=30000 here)
    in_valid = 1'b1; in_data = 16'sd500;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_out_data", out_data, 0);
    #1 rst = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("arst_no_output", ok, 1);
    cfg(3'd0, 16'sd16384);
    cfg(3'd1, 16'sd16384);
    cfg(3'd3, -16'sd8192);
    send("arst_pass", 16'sd1000, 16'sd1000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
